// File: rtl/shared_pkg.sv
// Shared types and constants for the FIFO read-side stream controller.
package shared_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    localparam int unsigned SKID_DEPTH = 3;

    // Skid-buffer pointer increment with wrap 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/fifo_skid_buffer.sv
// Three-entry circular skid buffer between the FIFO read port and the output stream.
module fifo_skid_buffer
    import shared_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       wr_ptr_d;
    logic [1:0]       rd_ptr_q;
    logic [1:0]       rd_ptr_d;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             do_pop_s;
    logic             do_push_s;

    // A push into a full buffer is only accepted when a pop frees a slot in the same cycle.
    assign do_pop_s  = pop_i && (count_q != 2'd0);
    assign do_push_s = push_i && ((count_q < 2'(SKID_DEPTH)) || do_pop_s);

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the synchronous FIFO read port in bursts and presents words on a valid/ready stream.
module fifo_stream_reader
    import shared_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned TIMEOUT    = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  empty,
    input  logic                  almostempty,
    input  logic                  underflow,
    input  logic [FIFO_WIDTH-1:0] data_out,
    output logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  err_underflow
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    rd_state_e            state_q;
    rd_state_e            state_d;
    logic [IDLE_W-1:0]    idle_cnt_q;
    logic [IDLE_W-1:0]    idle_cnt_d;
    logic                 inflight_q;
    logic [CNT_WIDTH-1:0] words_read_q;
    logic [CNT_WIDTH-1:0] words_read_d;
    logic                 err_q;
    logic                 err_d;
    logic                 rd_en_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 credit_ok_s;
    logic [2:0]           credit_sum_s;
    logic [1:0]           occ_s;

    fifo_skid_buffer #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (data_out),
        .pop_i       (pop_s),
        .head_o      (m_data),
        .count_o     (occ_s)
    );

    assign m_valid = (occ_s != 2'd0);
    assign pop_s   = m_valid & m_ready;
    // A read answered with underflow carries no data and must not occupy a slot.
    assign push_s  = inflight_q & ~underflow;

    // pop implies occupancy >= 1, so the sum never goes negative.
    assign credit_sum_s = {1'b0, occ_s} + {2'b00, inflight_q} - {2'b00, pop_s};
    assign credit_ok_s  = (credit_sum_s < 3'(SKID_DEPTH));

    // Burst FSM next-state, idle timeout counter and read request.
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        rd_en_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (empty) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_W'(TIMEOUT)) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end else begin
                    idle_cnt_d = idle_cnt_q;
                end
                if (!empty && (!almostempty || (idle_cnt_d == IDLE_W'(TIMEOUT)))) begin
                    state_d    = STREAM;
                    idle_cnt_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                rd_en_s    = !empty && credit_ok_s;
                idle_cnt_d = '0;
                if (empty && !inflight_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = STREAM;
                end
            end
            default: begin
                state_d    = IDLE;
                idle_cnt_d = '0;
            end
        endcase
    end

    // Delivered-word counter and sticky underflow flag next-state.
    always_comb begin
        words_read_d = words_read_q;
        err_d        = err_q;
        if (pop_s) begin
            words_read_d = words_read_q + CNT_WIDTH'(1);
        end else begin
            words_read_d = words_read_q;
        end
        if (inflight_q && underflow) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idle_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            words_read_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            inflight_q   <= rd_en_s;
            words_read_q <= words_read_d;
            err_q        <= err_d;
        end
    end

    assign rd_en         = rd_en_s;
    assign busy          = (state_q == STREAM);
    assign words_read    = words_read_q;
    assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO read-port model.
module tb_fifo_stream_reader;
    import shared_pkg::*;

    localparam int W  = 16;
    localparam int TO = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          empty;
    logic          almostempty;
    logic          underflow;
    logic [W-1:0]  data_out;
    logic          rd_en;
    logic [W-1:0]  m_data;
    logic          m_valid;
    logic          m_ready;
    logic          busy;
    logic [CW-1:0] words_read;
    logic          err_underflow;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .FIFO_WIDTH (W),
        .TIMEOUT    (TO),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .empty         (empty),
        .almostempty   (almostempty),
        .underflow     (underflow),
        .data_out      (data_out),
        .rd_en         (rd_en),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .busy          (busy),
        .words_read    (words_read),
        .err_underflow (err_underflow)
    );

    typedef struct {
        int           n;
        logic [W-1:0] base;
        logic [W-1:0] step;
        int           mode;
        int           exp_n;
        logic [W-1:0] exp_first;
        logic [W-1:0] exp_last;
    } vec_t;

    vec_t         tbl [5];
    int           tests = 0;
    int           fails = 0;
    int           viol  = 0;
    logic [W-1:0] fq     [$];
    logic [W-1:0] got    [$];
    logic [W-1:0] exp_q  [$];
    bit           rd_prev;
    bit           vld_prev;
    bit           inj_uf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    task automatic upd_flags();
        empty       = (fq.size() == 0);
        almostempty = (fq.size() == 1);
    endtask

    // One clock: sample DUT before the edge, then update the FIFO model as a registered read port.
    task automatic cyc();
        #1;
        rd_prev  = rd_en;
        vld_prev = m_valid;
        if (rd_en && empty) viol++;
        if (m_valid && m_ready) got.push_back(m_data);
        @(posedge clk);
        #1;
        underflow = 1'b0;
        if (rd_prev) begin
            if (inj_uf) begin
                inj_uf    = 1'b0;
                underflow = 1'b1;
                data_out  = 16'hDEAD;
            end else if (fq.size() > 0) begin
                data_out = fq.pop_front();
            end else begin
                underflow = 1'b1;
            end
        end
        upd_flags();
    endtask

    function automatic int order_err();
        int e = 0;
        if (got.size() != exp_q.size()) e++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) e++;
        end
        return e;
    endfunction

    task automatic load(input int n, input logic [W-1:0] base, input logic [W-1:0] step);
        logic [W-1:0] v;
        got.delete();
        exp_q.delete();
        v = base;
        for (int i = 0; i < n; i++) begin
            fq.push_back(v);
            exp_q.push_back(v);
            v = v + step;
        end
        upd_flags();
    endtask

    initial begin
        int           first_rd;
        int           last_rd;
        int           first_v;
        int           nrd;
        int           k;
        int           uf_seen;
        int           pushed;
        logic [CW-1:0] wr0;

        tbl[0] = '{2, 16'h1000, 16'h0001, 0, 2, 16'h1000, 16'h1001};
        tbl[1] = '{5, 16'hA000, 16'h0010, 1, 5, 16'hA000, 16'hA040};
        tbl[2] = '{3, 16'hFFFE, 16'h0001, 2, 3, 16'hFFFE, 16'h0000};
        tbl[3] = '{7, 16'h0100, 16'h0101, 2, 7, 16'h0100, 16'h0706};
        tbl[4] = '{1, 16'h7E57, 16'h0000, 0, 1, 16'h7E57, 16'h7E57};

        rst_n     = 1'b0;
        m_ready   = 1'b0;
        data_out  = '0;
        underflow = 1'b0;
        inj_uf    = 1'b0;
        rd_prev   = 1'b0;
        upd_flags();

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data", {16'b0, m_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_words_read", {16'b0, words_read}, 32'd0);
        chk("rst_err", {31'b0, err_underflow}, 32'd0);
        rst_n = 1'b1;

        // Four-word burst with m_ready high: latency and back-to-back reads.
        load(4, 16'h0011, 16'h0011);
        m_ready  = 1'b1;
        first_rd = -1; last_rd = -1; first_v = -1; nrd = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (rd_prev) begin
                nrd++;
                if (first_rd < 0) first_rd = c;
                last_rd = c;
            end
            if (vld_prev && first_v < 0) first_v = c;
        end
        chk("t1_first_rd", first_rd, 32'd1);
        chk("t1_last_rd", last_rd, 32'd4);
        chk("t1_nrd", nrd, 32'd4);
        chk("t1_latency", first_v - first_rd, 32'd2);
        chk("t1_order", order_err(), 32'd0);
        chk("t1_words_read", {16'b0, words_read}, 32'd4);
        chk("t1_idle", {31'b0, busy}, 32'd0);

        // Single word below the burst threshold: released by the idle timeout.
        load(1, 16'hBEEF, 16'h0000);
        first_rd = -1; nrd = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (rd_prev) begin
                nrd++;
                if (first_rd < 0) first_rd = c;
            end
        end
        chk("t2_first_rd", first_rd, TO);
        chk("t2_nrd", nrd, 32'd1);
        chk("t2_data", got.size() > 0 ? {16'b0, got[0]} : 32'hFFFF_FFFF, 32'h0000_BEEF);
        chk("t2_idle", {31'b0, busy}, 32'd0);

        // Six words with a stalled consumer: credit limit, then release.
        load(6, 16'h0011, 16'h0011);
        m_ready = 1'b0;
        nrd = 0;
        for (int c = 0; c < 15; c++) begin
            cyc();
            if (rd_prev) nrd++;
        end
        chk("t3_nrd", nrd, 32'd3);
        chk("t3_occ", {30'b0, dut.u_skid.count_q}, 32'd3);
        chk("t3_head", {16'b0, m_data}, 32'h0000_0011);
        chk("t3_valid", {31'b0, m_valid}, 32'd1);
        m_ready = 1'b1;
        k = 0;
        while (!(got.size() >= 6 && !busy && fq.size() == 0) && k < 100) begin
            cyc();
            k++;
        end
        if (k >= 100) bound_fail("t3_drain");
        chk("t3_order", order_err(), 32'd0);
        chk("t3_words_read", {16'b0, words_read}, 32'd11);

        // Injected underflow on the first issued read: flag sets, no buffer write.
        load(2, 16'h0A0A, 16'h0101);
        inj_uf  = 1'b1;
        uf_seen = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (underflow) begin
                uf_seen++;
                cyc();
                chk("t4_no_write", {30'b0, dut.u_skid.count_q}, 32'd0);
            end
        end
        chk("t4_uf_seen", uf_seen, 32'd1);
        chk("t4_err", {31'b0, err_underflow}, 32'd1);
        chk("t4_order", order_err(), 32'd0);
        chk("t4_words_read", {16'b0, words_read}, 32'd13);

        // Table of bursts with different lengths, data patterns and m_ready behaviour.
        for (int t = 0; t < 5; t++) begin
            wr0 = words_read;
            load(tbl[t].n, tbl[t].base, tbl[t].step);
            k = 0;
            while (!(got.size() >= tbl[t].n && !busy && fq.size() == 0) && k < 200) begin
                case (tbl[t].mode)
                    1:       m_ready = (k >= 10);
                    2:       m_ready = k[0];
                    default: m_ready = 1'b1;
                endcase
                cyc();
                k++;
            end
            if (k >= 200) bound_fail($sformatf("tbl%0d_drain", t));
            chk($sformatf("tbl%0d_count", t), got.size(), tbl[t].exp_n);
            chk($sformatf("tbl%0d_first", t), got.size() > 0 ? {16'b0, got[0]} : 32'hFFFF_FFFF,
                {16'b0, tbl[t].exp_first});
            chk($sformatf("tbl%0d_last", t), got.size() > 0 ? {16'b0, got[got.size()-1]} : 32'hFFFF_FFFF,
                {16'b0, tbl[t].exp_last});
            chk($sformatf("tbl%0d_order", t), order_err(), 32'd0);
            chk($sformatf("tbl%0d_words", t), {16'b0, CW'(words_read - wr0)}, tbl[t].exp_n);
        end
        chk("t4_err_sticky", {31'b0, err_underflow}, 32'd1);

        // Asynchronous reset mid-burst with two words buffered.
        load(6, 16'h0101, 16'h0101);
        m_ready = 1'b0;
        k = 0;
        while (dut.u_skid.count_q != 2'd2 && k < 20) begin
            cyc();
            k++;
        end
        if (k >= 20) bound_fail("t5_fill");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_m_valid", {31'b0, m_valid}, 32'd0);
        chk("t5_words_read", {16'b0, words_read}, 32'd0);
        chk("t5_state", {31'b0, dut.state_q}, {31'b0, IDLE});
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_m_data", {16'b0, m_data}, 32'd0);
        chk("t5_err", {31'b0, err_underflow}, 32'd0);
        fq.delete();
        got.delete();
        data_out  = '0;
        underflow = 1'b0;
        inj_uf    = 1'b0;
        rd_prev   = 1'b0;
        upd_flags();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1000 words trickled in with a random consumer.
        got.delete();
        exp_q.delete();
        pushed = 0;
        k = 0;
        while (!(got.size() >= 1000 && !busy && fq.size() == 0) && k < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
                fq.push_back(16'(pushed) ^ 16'h5A5A);
                exp_q.push_back(16'(pushed) ^ 16'h5A5A);
                pushed++;
                upd_flags();
            end
            m_ready = 1'($urandom_range(0, 1));
            cyc();
            k++;
        end
        if (k >= 20000) bound_fail("t6_drain");
        chk("t6_count", got.size(), 32'd1000);
        chk("t6_order", order_err(), 32'd0);
        chk("t6_words_read", {16'b0, words_read}, 32'd1000);
        chk("t6_err", {31'b0, err_underflow}, 32'd0);
        chk("no_rd_while_empty", viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
